rvx_core_trap_controller: RTL and testbench
===========================================

RVX_CORE_TRAP_CONTROLLER -- requirements
Module: rvx_core_trap_controller

Interface
REQ-001 SHALL have these ports, clock and reset first:
  - clock  in  1  core clock
  - reset_n  in  1  synchronous active-low reset
  - clock_enable  in  1  gates all state updates
  - core_state_s1  in  4  core FSM state (RVX_STATE_*)
  - pc_s1  in  32  PC of the stage-1 instruction
  - ex_fetch_misaligned_s1, ex_illegal_s1, ex_ebreak_s1, ex_ecall_s1, ex_load_misaligned_s1, ex_store_misaligned_s1  in  1 each  exception requests
  - ex_tval_s1  in  32  faulting address or instruction bits
  - mret_s1  in  1  MRET decoded
  - irq_external, irq_timer, irq_software  in  1 each  level-sensitive interrupt lines
  - mtvec  in  32  trap vector base; bits [1:0] are the mode
  - csr_write_enable  in  1  CSR write strobe
  - csr_address  in  12  CSR address
  - csr_write_data  in  32  CSR write value
  - take_trap_s1  out  1  to the core state FSM
  - trap_target_s1  out  32  next PC on a trap or on MRET
  - mepc, mcause, mtval, mstatus, mie, mip  out  32 each  CSR read values
REQ-002 SHALL have no parameters.

Function
REQ-003 take_trap_s1 SHALL be combinational: core_state_s1 == OPERATING AND (any exception, OR (mstatus.MIE AND any bit of mie&mip)).
REQ-004 take_trap_s1 SHALL be 0 in RESET, TRAP_TAKEN and TRAP_RETURN states, whatever the requests.
REQ-005 mip SHALL be {20'b0, MEIP at bit 11, 3'b0, MTIP at bit 7, 3'b0, MSIP at bit 3, 3'b0}, sampled each cycle; mip SHALL be read-only.
REQ-006 Interrupts SHALL take priority over exceptions; among interrupts the order SHALL be MEI (11) > MSI (3) > MTI (7).
REQ-007 Exception priority SHALL be fetch-misaligned (0) > illegal (2) > ebreak (3) > ecall-M (11) > load-misaligned (4) > store-misaligned (6).
REQ-008 On take_trap_s1 AND clock_enable, one edge SHALL perform all of:
  - mepc <= {pc_s1[31:2], 2'b00}
  - mcause <= {interrupt flag, 27'b0, code}
  - mtval <= ex_tval_s1 for cause codes 0, 2, 4 and 6, and 0 otherwise
  - MPIE <= MIE, MIE <= 0, MPP held at 2'b11
REQ-009 On mret_s1 AND core_state_s1 == OPERATING AND NOT take_trap_s1 AND clock_enable: MIE <= MPIE, MPIE <= 1.
REQ-010 trap_target_s1 SHALL be {mepc[31:2], 2'b00} when mret_s1 is set and no trap is being taken; otherwise it SHALL be the trap address per REQ-017/018.
REQ-011 CSR writes SHALL apply on the next edge when csr_write_enable AND clock_enable:
  - mstatus (0x300): only MIE (bit 3) and MPIE (bit 7) are writable
  - mie (0x304): only bits 11, 7 and 3 are writable
  - mepc (0x341): bits [1:0] forced to 0
  - mcause (0x342), mtval (0x343): fully writable
  - any other address: ignored
REQ-012 Simultaneous events: a trap update SHALL override a CSR write to the same register in that cycle; a trap SHALL override MRET.
REQ-013 With clock_enable = 0, all registers SHALL hold their values; combinational outputs SHALL still follow the inputs.
REQ-014 An exception raised while mstatus.MIE = 0 SHALL still trap.

Reset
REQ-015 When reset_n = 0 at an edge, the following SHALL be 0, regardless of clock_enable:
  - mepc, mcause, mtval
  - mie
  - mstatus.MIE and mstatus.MPIE
  - mstatus reads as 32'h0000_1800 (MPP = 11)
REQ-016 Reset in the middle of a trap sequence SHALL discard all pending trap updates; take_trap_s1 SHALL be 0 while core_state_s1 == RESET.

Configuration
REQ-017 With RVX_TRAP_VECTORED_EN defined, when mtvec[1:0] == 01 and the trap is an interrupt, the trap address SHALL be {mtvec[31:2], 2'b00} + 4*code.
REQ-018 The trap address SHALL be {mtvec[31:2], 2'b00} in these cases:
  - RVX_TRAP_VECTORED_EN is not defined (the mode bits are ignored)
  - mtvec[1:0] != 01
  - the trap is an exception

Structure
REQ-019 Cause codes, CSR addresses and mip/mie bit positions SHALL be defined as macros in rvx_core_constants.vh, next to the RVX_STATE_* codes.
REQ-020 The priority encoder SHALL be one sub-module, rvx_core_trap_priority; its inputs are the request vectors and its outputs are {valid, interrupt, code[3:0]}.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - ex_illegal_s1 = 1 with pc_s1 = 32'h0000_0104, tval = 32'hDEAD_BEEF -> take_trap_s1 = 1; after the edge: mepc = 0x104, mcause = 2, mtval = 0xDEADBEEF, MIE = 0, MPIE = previous MIE.
  - MIE = 1, mie = 0x880, irq_timer and irq_external both high -> mcause = 0x8000_000B; with the macro defined and mtvec = 0x0000_1001 -> trap_target_s1 = 0x102C.
  - core_state_s1 = TRAP_TAKEN while ex_ecall_s1 = 1 -> take_trap_s1 = 0 and no register changes.
  - mret_s1 with MPIE = 1 and mepc = 0x200 -> trap_target_s1 = 0x200; after the edge MIE = 1 and MPIE = 1.
  - Same cycle: csr write of mepc = 0x300 and a trap at pc 0x40 -> mepc = 0x40; writing mepc = 0x303 -> mepc reads 0x300.
  - reset_n = 0 after a trap -> all CSRs at their REQ-015 values; with clock_enable = 0 and a request asserted -> no register changes.

Source files
------------

// File: rtl/rvx_core_trap_controller_pkg.sv
// Types and helpers shared by the trap controller and its priority encoder.
`include "rvx_core_constants.vh"

package rvx_core_trap_controller_pkg;

  // Interrupt request vector, highest priority in the MSB.
  localparam int IRQ_W = 3;
  localparam int IRQ_MEI_IDX = 2;
  localparam int IRQ_MSI_IDX = 1;
  localparam int IRQ_MTI_IDX = 0;

  // Exception request vector, highest priority in the MSB.
  localparam int EX_W = 6;
  localparam int EX_FETCH_IDX = 5;
  localparam int EX_ILLEGAL_IDX = 4;
  localparam int EX_EBREAK_IDX = 3;
  localparam int EX_ECALL_IDX = 2;
  localparam int EX_LOAD_IDX = 1;
  localparam int EX_STORE_IDX = 0;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  typedef enum logic [3:0] {
    STATE_RESET       = `RVX_STATE_RESET,
    STATE_OPERATING   = `RVX_STATE_OPERATING,
    STATE_TRAP_TAKEN  = `RVX_STATE_TRAP_TAKEN,
    STATE_TRAP_RETURN = `RVX_STATE_TRAP_RETURN
  } core_state_e;

  // Only address-type exceptions and illegal instructions report a tval.
  function automatic logic cause_has_tval(input logic interrupt, input logic [3:0] code);
    logic hit;
    hit = 1'b0;
    if (!interrupt) begin
      case (code)
        `RVX_CAUSE_FETCH_MISALIGNED,
        `RVX_CAUSE_ILLEGAL,
        `RVX_CAUSE_LOAD_MISALIGNED,
        `RVX_CAUSE_STORE_MISALIGNED: hit = 1'b1;
        default:                     hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/rvx_core_constants.vh
// Shared core constants: core FSM state codes, trap cause codes, CSR addresses
// and mip/mie/mstatus bit positions.
`ifndef RVX_CORE_CONSTANTS_VH
`define RVX_CORE_CONSTANTS_VH

`define RVX_STATE_RESET             4'd0
`define RVX_STATE_OPERATING         4'd1
`define RVX_STATE_TRAP_TAKEN        4'd2
`define RVX_STATE_TRAP_RETURN       4'd3

`define RVX_CAUSE_FETCH_MISALIGNED  4'd0
`define RVX_CAUSE_ILLEGAL           4'd2
`define RVX_CAUSE_EBREAK            4'd3
`define RVX_CAUSE_LOAD_MISALIGNED   4'd4
`define RVX_CAUSE_STORE_MISALIGNED  4'd6
`define RVX_CAUSE_ECALL_M           4'd11
`define RVX_CAUSE_IRQ_MSI           4'd3
`define RVX_CAUSE_IRQ_MTI           4'd7
`define RVX_CAUSE_IRQ_MEI           4'd11

`define RVX_CSR_MSTATUS             12'h300
`define RVX_CSR_MIE                 12'h304
`define RVX_CSR_MEPC                12'h341
`define RVX_CSR_MCAUSE              12'h342
`define RVX_CSR_MTVAL               12'h343
`define RVX_CSR_MIP                 12'h344

`define RVX_BIT_MSI                 3
`define RVX_BIT_MTI                 7
`define RVX_BIT_MEI                 11
`define RVX_MSTATUS_MIE             3
`define RVX_MSTATUS_MPIE            7

`endif

// File: rtl/rvx_core_trap_priority.sv
// Fixed-priority selection of the trap cause: enabled interrupts beat exceptions.
module rvx_core_trap_priority
  import rvx_core_trap_controller_pkg::*;
(
  input  logic [IRQ_W-1:0] irq_request,
  input  logic [EX_W-1:0]  ex_request,
  output logic             valid,
  output logic             interrupt,
  output logic [3:0]       code
);

  always_comb begin
    valid     = 1'b0;
    interrupt = 1'b0;
    code      = 4'd0;
    if (|irq_request) begin
      valid     = 1'b1;
      interrupt = 1'b1;
      if (irq_request[IRQ_MEI_IDX])      code = `RVX_CAUSE_IRQ_MEI;
      else if (irq_request[IRQ_MSI_IDX]) code = `RVX_CAUSE_IRQ_MSI;
      else                               code = `RVX_CAUSE_IRQ_MTI;
    end else if (|ex_request) begin
      valid = 1'b1;
      if (ex_request[EX_FETCH_IDX])        code = `RVX_CAUSE_FETCH_MISALIGNED;
      else if (ex_request[EX_ILLEGAL_IDX]) code = `RVX_CAUSE_ILLEGAL;
      else if (ex_request[EX_EBREAK_IDX])  code = `RVX_CAUSE_EBREAK;
      else if (ex_request[EX_ECALL_IDX])   code = `RVX_CAUSE_ECALL_M;
      else if (ex_request[EX_LOAD_IDX])    code = `RVX_CAUSE_LOAD_MISALIGNED;
      else                                 code = `RVX_CAUSE_STORE_MISALIGNED;
    end
  end

endmodule

// File: rtl/rvx_core_trap_controller.sv
// Machine-mode trap controller: trap decision, target PC and the trap CSRs.
// Optional macro RVX_TRAP_VECTORED_EN enables vectored interrupt dispatch.
module rvx_core_trap_controller
  import rvx_core_trap_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_enable,
  input  logic [3:0]  core_state_s1,
  input  logic [31:0] pc_s1,
  input  logic        ex_fetch_misaligned_s1,
  input  logic        ex_illegal_s1,
  input  logic        ex_ebreak_s1,
  input  logic        ex_ecall_s1,
  input  logic        ex_load_misaligned_s1,
  input  logic        ex_store_misaligned_s1,
  input  logic [31:0] ex_tval_s1,
  input  logic        mret_s1,
  input  logic        irq_external,
  input  logic        irq_timer,
  input  logic        irq_software,
  input  logic [31:0] mtvec,
  input  logic        csr_write_enable,
  input  logic [11:0] csr_address,
  input  logic [31:0] csr_write_data,
  output logic        take_trap_s1,
  output logic [31:0] trap_target_s1,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic [31:0] mstatus,
  output logic [31:0] mie,
  output logic [31:0] mip
);

  logic [29:0]      mepc_q;
  logic [31:0]      mcause_q;
  logic [31:0]      mtval_q;
  logic             status_mie;
  logic             status_mpie;
  logic             enable_mei;
  logic             enable_mti;
  logic             enable_msi;

  logic [IRQ_W-1:0] irq_request;
  logic [EX_W-1:0]  ex_request;
  logic             cause_valid;
  logic             cause_interrupt;
  logic [3:0]       cause_code;
  logic             operating;
  logic             mret_taken;
  logic [31:0]      vector_base;
  logic [31:0]      trap_address;
  logic [1:0]       unused_pc_low;

  assign unused_pc_low = pc_s1[1:0];

  assign mip = {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};
  assign mie = {20'b0, enable_mei, 3'b0, enable_mti, 3'b0, enable_msi, 3'b0};
  assign mstatus = {19'b0, MSTATUS_MPP_M, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};
  assign mepc = {mepc_q, 2'b00};
  assign mcause = mcause_q;
  assign mtval = mtval_q;

  always_comb begin
    irq_request = '0;
    irq_request[IRQ_MEI_IDX] = status_mie & enable_mei & irq_external;
    irq_request[IRQ_MSI_IDX] = status_mie & enable_msi & irq_software;
    irq_request[IRQ_MTI_IDX] = status_mie & enable_mti & irq_timer;
  end

  always_comb begin
    ex_request = '0;
    ex_request[EX_FETCH_IDX]   = ex_fetch_misaligned_s1;
    ex_request[EX_ILLEGAL_IDX] = ex_illegal_s1;
    ex_request[EX_EBREAK_IDX]  = ex_ebreak_s1;
    ex_request[EX_ECALL_IDX]   = ex_ecall_s1;
    ex_request[EX_LOAD_IDX]    = ex_load_misaligned_s1;
    ex_request[EX_STORE_IDX]   = ex_store_misaligned_s1;
  end

  rvx_core_trap_priority u_priority (
    .irq_request (irq_request),
    .ex_request  (ex_request),
    .valid       (cause_valid),
    .interrupt   (cause_interrupt),
    .code        (cause_code)
  );

  assign operating    = (core_state_s1 == STATE_OPERATING);
  assign take_trap_s1 = operating & cause_valid;
  assign mret_taken   = operating & mret_s1 & ~take_trap_s1;
  assign vector_base  = {mtvec[31:2], 2'b00};

`ifdef RVX_TRAP_VECTORED_EN
  always_comb begin
    trap_address = vector_base;
    if (mtvec[1:0] == MTVEC_MODE_VECTORED && cause_interrupt)
      trap_address = vector_base + {26'b0, cause_code, 2'b00};
  end
`else
  logic [1:0] unused_mtvec_mode;
  assign unused_mtvec_mode = mtvec[1:0];
  assign trap_address = vector_base;
`endif

  assign trap_target_s1 = (mret_s1 && !take_trap_s1) ? {mepc_q, 2'b00} : trap_address;

  // Trap and MRET updates come after the CSR write so they win on conflicts.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      enable_mei  <= 1'b0;
      enable_mti  <= 1'b0;
      enable_msi  <= 1'b0;
    end else if (clock_enable) begin
      if (csr_write_enable) begin
        case (csr_address)
          `RVX_CSR_MSTATUS: begin
            status_mie  <= csr_write_data[`RVX_MSTATUS_MIE];
            status_mpie <= csr_write_data[`RVX_MSTATUS_MPIE];
          end
          `RVX_CSR_MIE: begin
            enable_mei <= csr_write_data[`RVX_BIT_MEI];
            enable_mti <= csr_write_data[`RVX_BIT_MTI];
            enable_msi <= csr_write_data[`RVX_BIT_MSI];
          end
          `RVX_CSR_MEPC:   mepc_q   <= csr_write_data[31:2];
          `RVX_CSR_MCAUSE: mcause_q <= csr_write_data;
          `RVX_CSR_MTVAL:  mtval_q  <= csr_write_data;
          default: ;
        endcase
      end
      if (take_trap_s1) begin
        mepc_q      <= pc_s1[31:2];
        mcause_q    <= {cause_interrupt, 27'b0, cause_code};
        mtval_q     <= cause_has_tval(cause_interrupt, cause_code) ? ex_tval_s1 : 32'h0;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (mret_taken) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvx_core_trap_controller.sv
// Directed self-checking bench for rvx_core_trap_controller.
module tb_rvx_core_trap_controller;
  import rvx_core_trap_controller_pkg::*;

`ifdef RVX_TRAP_VECTORED_EN
  localparam logic [31:0] EXP_MEI_TARGET = 32'h0000_102C;
  localparam logic [31:0] EXP_MSI_TARGET = 32'h0000_100C;
`else
  localparam logic [31:0] EXP_MEI_TARGET = 32'h0000_1000;
  localparam logic [31:0] EXP_MSI_TARGET = 32'h0000_1000;
`endif

  logic        clock = 1'b0;
  logic        reset_n, clock_enable;
  logic [3:0]  core_state_s1;
  logic [31:0] pc_s1, ex_tval_s1, mtvec, csr_write_data;
  logic        ex_fetch_misaligned_s1, ex_illegal_s1, ex_ebreak_s1, ex_ecall_s1;
  logic        ex_load_misaligned_s1, ex_store_misaligned_s1, mret_s1;
  logic        irq_external, irq_timer, irq_software, csr_write_enable;
  logic [11:0] csr_address;
  logic        take_trap_s1;
  logic [31:0] trap_target_s1, mepc, mcause, mtval, mstatus, mie, mip;

  int assertions = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rvx_core_trap_controller dut (
    .clock(clock), .reset_n(reset_n), .clock_enable(clock_enable),
    .core_state_s1(core_state_s1), .pc_s1(pc_s1),
    .ex_fetch_misaligned_s1(ex_fetch_misaligned_s1), .ex_illegal_s1(ex_illegal_s1),
    .ex_ebreak_s1(ex_ebreak_s1), .ex_ecall_s1(ex_ecall_s1),
    .ex_load_misaligned_s1(ex_load_misaligned_s1), .ex_store_misaligned_s1(ex_store_misaligned_s1),
    .ex_tval_s1(ex_tval_s1), .mret_s1(mret_s1),
    .irq_external(irq_external), .irq_timer(irq_timer), .irq_software(irq_software),
    .mtvec(mtvec), .csr_write_enable(csr_write_enable), .csr_address(csr_address),
    .csr_write_data(csr_write_data), .take_trap_s1(take_trap_s1),
    .trap_target_s1(trap_target_s1), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mstatus(mstatus), .mie(mie), .mip(mip)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    core_state_s1 = STATE_OPERATING;
    ex_fetch_misaligned_s1 = 0; ex_illegal_s1 = 0; ex_ebreak_s1 = 0; ex_ecall_s1 = 0;
    ex_load_misaligned_s1 = 0; ex_store_misaligned_s1 = 0; mret_s1 = 0;
    irq_external = 0; irq_timer = 0; irq_software = 0;
    csr_write_enable = 0; csr_address = 12'h0; csr_write_data = 32'h0;
    pc_s1 = 32'h0; ex_tval_s1 = 32'h0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    csr_write_enable = 1; csr_address = addr; csr_write_data = data;
    step();
    csr_write_enable = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; clock_enable = 1; mtvec = 32'h0000_1000;
    idle();
    core_state_s1 = STATE_RESET;
    step(); step();
    assertions++; if (mepc !== 32'h0) begin failures++; $display("FAIL rst_mepc got %h want %h", mepc, 32'h0); end
    assertions++; if (mcause !== 32'h0) begin failures++; $display("FAIL rst_mcause got %h want %h", mcause, 32'h0); end
    assertions++; if (mtval !== 32'h0) begin failures++; $display("FAIL rst_mtval got %h want %h", mtval, 32'h0); end
    assertions++; if (mie !== 32'h0) begin failures++; $display("FAIL rst_mie got %h want %h", mie, 32'h0); end
    assertions++; if (mstatus !== 32'h0000_1800) begin failures++; $display("FAIL rst_mstatus got %h want %h", mstatus, 32'h1800); end
    ex_illegal_s1 = 1; #1;
    assertions++; if (take_trap_s1 !== 1'b0) begin failures++; $display("FAIL rst_take got %b want 0", take_trap_s1); end
    idle();
    reset_n = 1;
    step();
  endtask

  task automatic test_exception();
    csr_wr(12'h300, 32'h0000_0008);
    assertions++; if (mstatus !== 32'h0000_1808) begin failures++; $display("FAIL ex_mstatus_wr got %h want %h", mstatus, 32'h1808); end
    ex_illegal_s1 = 1; pc_s1 = 32'h0000_0104; ex_tval_s1 = 32'hDEAD_BEEF; #1;
    assertions++; if (take_trap_s1 !== 1'b1) begin failures++; $display("FAIL ex_take got %b want 1", take_trap_s1); end
    assertions++; if (trap_target_s1 !== 32'h0000_1000) begin failures++; $display("FAIL ex_target got %h want %h", trap_target_s1, 32'h1000); end
    step(); idle();
    assertions++; if (mepc !== 32'h0000_0104) begin failures++; $display("FAIL ex_mepc got %h want %h", mepc, 32'h104); end
    assertions++; if (mcause !== 32'h0000_0002) begin failures++; $display("FAIL ex_mcause got %h want %h", mcause, 32'h2); end
    assertions++; if (mtval !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ex_mtval got %h want %h", mtval, 32'hDEADBEEF); end
    assertions++; if (mstatus !== 32'h0000_1880) begin failures++; $display("FAIL ex_mstatus got %h want %h", mstatus, 32'h1880); end
    // MIE is now 0; exceptions still trap, load-misaligned beats store-misaligned
    ex_load_misaligned_s1 = 1; ex_store_misaligned_s1 = 1; pc_s1 = 32'h0000_010A; ex_tval_s1 = 32'h0000_0123; #1;
    assertions++; if (take_trap_s1 !== 1'b1) begin failures++; $display("FAIL ex_mie0_take got %b want 1", take_trap_s1); end
    step(); idle();
    assertions++; if (mepc !== 32'h0000_0108) begin failures++; $display("FAIL ex_ld_mepc got %h want %h", mepc, 32'h108); end
    assertions++; if (mcause !== 32'h0000_0004) begin failures++; $display("FAIL ex_ld_mcause got %h want %h", mcause, 32'h4); end
    assertions++; if (mtval !== 32'h0000_0123) begin failures++; $display("FAIL ex_ld_mtval got %h want %h", mtval, 32'h123); end
    assertions++; if (mstatus !== 32'h0000_1800) begin failures++; $display("FAIL ex_ld_mstatus got %h want %h", mstatus, 32'h1800); end
  endtask

  task automatic test_interrupt();
    csr_wr(12'h304, 32'hFFFF_FFFF);
    assertions++; if (mie !== 32'h0000_0888) begin failures++; $display("FAIL irq_mie_mask got %h want %h", mie, 32'h888); end
    csr_wr(12'h304, 32'h0000_0880);
    csr_wr(12'h300, 32'h0000_0008);
    mtvec = 32'h0000_1001;
    irq_timer = 1; irq_external = 1; ex_ecall_s1 = 1; pc_s1 = 32'h0000_0080; #1;
    assertions++; if (take_trap_s1 !== 1'b1) begin failures++; $display("FAIL irq_take got %b want 1", take_trap_s1); end
    assertions++; if (trap_target_s1 !== EXP_MEI_TARGET) begin failures++; $display("FAIL irq_target got %h want %h", trap_target_s1, EXP_MEI_TARGET); end
    step();
    assertions++; if (mip !== 32'h0000_0880) begin failures++; $display("FAIL irq_mip got %h want %h", mip, 32'h880); end
    assertions++; if (mcause !== 32'h8000_000B) begin failures++; $display("FAIL irq_mcause got %h want %h", mcause, 32'h8000000B); end
    assertions++; if (mtval !== 32'h0) begin failures++; $display("FAIL irq_mtval got %h want %h", mtval, 32'h0); end
    assertions++; if (mepc !== 32'h0000_0080) begin failures++; $display("FAIL irq_mepc got %h want %h", mepc, 32'h80); end
    assertions++; if (mstatus !== 32'h0000_1880) begin failures++; $display("FAIL irq_mstatus got %h want %h", mstatus, 32'h1880); end
    ex_ecall_s1 = 0; #1;
    assertions++; if (take_trap_s1 !== 1'b0) begin failures++; $display("FAIL irq_masked_take got %b want 0", take_trap_s1); end
    idle();
    csr_wr(12'h304, 32'h0000_0088);
    csr_wr(12'h300, 32'h0000_0008);
    irq_software = 1; irq_timer = 1; irq_external = 1; pc_s1 = 32'h0000_0090; #1;
    assertions++; if (trap_target_s1 !== EXP_MSI_TARGET) begin failures++; $display("FAIL msi_target got %h want %h", trap_target_s1, EXP_MSI_TARGET); end
    step(); idle();
    assertions++; if (mcause !== 32'h8000_0003) begin failures++; $display("FAIL msi_mcause got %h want %h", mcause, 32'h80000003); end
    assertions++; if (mepc !== 32'h0000_0090) begin failures++; $display("FAIL msi_mepc got %h want %h", mepc, 32'h90); end
  endtask

  task automatic test_blocked_states();
    core_state_s1 = STATE_TRAP_TAKEN; ex_ecall_s1 = 1; pc_s1 = 32'h0000_0998; ex_tval_s1 = 32'h55; #1;
    assertions++; if (take_trap_s1 !== 1'b0) begin failures++; $display("FAIL blk_take got %b want 0", take_trap_s1); end
    step();
    assertions++; if (mepc !== 32'h0000_0090) begin failures++; $display("FAIL blk_mepc got %h want %h", mepc, 32'h90); end
    assertions++; if (mcause !== 32'h8000_0003) begin failures++; $display("FAIL blk_mcause got %h want %h", mcause, 32'h80000003); end
    core_state_s1 = STATE_TRAP_RETURN; mret_s1 = 1; #1;
    assertions++; if (take_trap_s1 !== 1'b0) begin failures++; $display("FAIL blk_ret_take got %b want 0", take_trap_s1); end
    step(); idle();
    assertions++; if (mstatus !== 32'h0000_1880) begin failures++; $display("FAIL blk_mstatus got %h want %h", mstatus, 32'h1880); end
  endtask

  task automatic test_mret();
    mtvec = 32'h0000_1000;
    csr_wr(12'h341, 32'h0000_0200);
    csr_wr(12'h300, 32'h0000_0080);
    mret_s1 = 1; #1;
    assertions++; if (take_trap_s1 !== 1'b0) begin failures++; $display("FAIL mret_take got %b want 0", take_trap_s1); end
    assertions++; if (trap_target_s1 !== 32'h0000_0200) begin failures++; $display("FAIL mret_target got %h want %h", trap_target_s1, 32'h200); end
    step();
    assertions++; if (mstatus !== 32'h0000_1888) begin failures++; $display("FAIL mret_mstatus got %h want %h", mstatus, 32'h1888); end
    ex_ecall_s1 = 1; pc_s1 = 32'h0000_0300; #1;
    assertions++; if (trap_target_s1 !== 32'h0000_1000) begin failures++; $display("FAIL mret_vs_trap_target got %h want %h", trap_target_s1, 32'h1000); end
    step(); idle();
    assertions++; if (mcause !== 32'h0000_000B) begin failures++; $display("FAIL mret_vs_trap_mcause got %h want %h", mcause, 32'hB); end
    assertions++; if (mstatus !== 32'h0000_1880) begin failures++; $display("FAIL mret_vs_trap_mstatus got %h want %h", mstatus, 32'h1880); end
  endtask

  task automatic test_csr_collision();
    csr_write_enable = 1; csr_address = 12'h341; csr_write_data = 32'h0000_0300;
    ex_ebreak_s1 = 1; pc_s1 = 32'h0000_0040;
    step(); idle();
    assertions++; if (mepc !== 32'h0000_0040) begin failures++; $display("FAIL col_mepc got %h want %h", mepc, 32'h40); end
    assertions++; if (mcause !== 32'h0000_0003) begin failures++; $display("FAIL col_mcause got %h want %h", mcause, 32'h3); end
    csr_wr(12'h341, 32'h0000_0303);
    assertions++; if (mepc !== 32'h0000_0300) begin failures++; $display("FAIL mepc_align got %h want %h", mepc, 32'h300); end
    csr_wr(12'h344, 32'h0000_FFFF);
    assertions++; if (mip !== 32'h0) begin failures++; $display("FAIL mip_ro got %h want %h", mip, 32'h0); end
    csr_wr(12'h342, 32'h1234_5678);
    csr_wr(12'h343, 32'hCAFE_F00D);
    assertions++; if (mcause !== 32'h1234_5678) begin failures++; $display("FAIL mcause_wr got %h want %h", mcause, 32'h12345678); end
    assertions++; if (mtval !== 32'hCAFE_F00D) begin failures++; $display("FAIL mtval_wr got %h want %h", mtval, 32'hCAFEF00D); end
  endtask

  task automatic test_clock_enable();
    clock_enable = 0;
    ex_illegal_s1 = 1; pc_s1 = 32'h0000_0500; ex_tval_s1 = 32'h77;
    csr_write_enable = 1; csr_address = 12'h343; csr_write_data = 32'h0; #1;
    assertions++; if (take_trap_s1 !== 1'b1) begin failures++; $display("FAIL ce_take got %b want 1", take_trap_s1); end
    step();
    assertions++; if (mepc !== 32'h0000_0300) begin failures++; $display("FAIL ce_mepc got %h want %h", mepc, 32'h300); end
    assertions++; if (mtval !== 32'hCAFE_F00D) begin failures++; $display("FAIL ce_mtval got %h want %h", mtval, 32'hCAFEF00D); end
    assertions++; if (mcause !== 32'h1234_5678) begin failures++; $display("FAIL ce_mcause got %h want %h", mcause, 32'h12345678); end
    idle();
    clock_enable = 1;
  endtask

  task automatic test_reset_mid_trap();
    ex_fetch_misaligned_s1 = 1; pc_s1 = 32'h0000_0600; #1;
    assertions++; if (take_trap_s1 !== 1'b1) begin failures++; $display("FAIL rm_pre_take got %b want 1", take_trap_s1); end
    reset_n = 0; clock_enable = 0; core_state_s1 = STATE_RESET; #1;
    assertions++; if (take_trap_s1 !== 1'b0) begin failures++; $display("FAIL rm_take got %b want 0", take_trap_s1); end
    step();
    assertions++; if (mepc !== 32'h0) begin failures++; $display("FAIL rm_mepc got %h want %h", mepc, 32'h0); end
    assertions++; if (mcause !== 32'h0) begin failures++; $display("FAIL rm_mcause got %h want %h", mcause, 32'h0); end
    assertions++; if (mtval !== 32'h0) begin failures++; $display("FAIL rm_mtval got %h want %h", mtval, 32'h0); end
    assertions++; if (mie !== 32'h0) begin failures++; $display("FAIL rm_mie got %h want %h", mie, 32'h0); end
    assertions++; if (mstatus !== 32'h0000_1800) begin failures++; $display("FAIL rm_mstatus got %h want %h", mstatus, 32'h1800); end
    idle();
    reset_n = 1; clock_enable = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_blocked_states();
    test_mret();
    test_csr_collision();
    test_clock_enable();
    test_reset_mid_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
